lifo_arbiter: RTL

- Shares one Lifo stack instance between two independent requesters (port 0, port 1).
- Each requester issues push or pop transactions with a req/ack handshake. The block arbitrates between them, sequences the stack's rd/wr strobes one transaction at a time, captures pop data, and flags rejected operations (push when full, pop when empty).
- Sits between the Lifo instance and client logic (button/debounce front ends, test sequencers) in the stack-buffer lab design.

---
 rtl/lifo_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: shares one Lifo stack between two push/pop requesters.
//   Grants one transaction at a time (IDLE -> ISSUE -> DONE), drives the Lifo
//   rd/wr strobes, captures pop data and flags push-when-full / pop-when-empty.
//   Latency: req sampled at edge k, strobe in cycle k+1, ack in cycle k+2;
//   one transaction per 3 cycles.
//   Backpressure: a requester holds req/op/wdata until its ack pulse.
// Ports:
//   clk, CPU_RESETN            clock, async active-low reset
//   req0/op0/wdata0            port 0 request (op 1 = push, 0 = pop)
//   req1/op1/wdata1            port 1 request
//   ack0, ack1, err, rdata     completion pulse, reject flag, pop result
//   busy                       transaction in flight
//   lifo_rd/lifo_wr/lifo_w_data, lifo_r_data/lifo_full/lifo_empty  Lifo side
// Build option: define LIFO_ARB_FIXED_PRIO_EN to make port 0 always win on
//   contention (round-robin pointer removed); default is round-robin.
module lifo_arbiter #(
  parameter int B = 3,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         CPU_RESETN,
  input  logic         req0,
  input  logic         op0,
  input  logic [B-1:0] wdata0,
  input  logic         req1,
  input  logic         op1,
  input  logic [B-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic         err,
  output logic [B-1:0] rdata,
  output logic         busy,
  output logic         lifo_rd,
  output logic         lifo_wr,
  output logic [B-1:0] lifo_w_data,
  input  logic [B-1:0] lifo_r_data,
  input  logic         lifo_full,
  input  logic         lifo_empty
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [W:0] DEPTH = (W+1)'(1 << W);

  state_t         r_state;
  state_t         w_next;
  logic           r_gnt;      // granted port of the in-flight transaction
  logic           r_op;       // 1 = push
  logic [B-1:0]   r_wdata;
  logic           r_full;     // full/empty snapshot taken at grant time
  logic           r_empty;
  logic           r_err;
  logic [B-1:0]   r_rdata;
  logic [W:0]     r_occ;      // local occupancy, backs up the Lifo flags

  logic           w_any;
  logic           w_win;
  logic           w_full;
  logic           w_empty;
  logic           w_push_ok;
  logic           w_pop_ok;

  assign w_any   = req0 | req1;
  // Either the Lifo's own flag or our occupancy count can block an operation,
  // so a stale or glitching flag never lets the stack over/underflow.
  assign w_full  = lifo_full  | (r_occ == DEPTH);
  assign w_empty = lifo_empty | (r_occ == '0);

`ifdef LIFO_ARB_FIXED_PRIO_EN
  // Port 0 wins whenever it requests.
  assign w_win = ~req0;
`else
  logic r_ptr;  // preferred port on contention
  assign w_win = (req0 & req1) ? r_ptr : req1;

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_ptr <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_ptr <= ~r_gnt;
    end
  end
`endif

  // Strobes are decoded from the state register, so an async reset drops
  // them immediately.
  assign w_push_ok = (r_state == S_ISSUE) &  r_op & ~r_full;
  assign w_pop_ok  = (r_state == S_ISSUE) & ~r_op & ~r_empty;

  // State register
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and outputs
  always_comb begin
    w_next      = r_state;
    ack0        = 1'b0;
    ack1        = 1'b0;
    err         = 1'b0;
    busy        = 1'b0;
    lifo_wr     = 1'b0;
    lifo_rd     = 1'b0;
    lifo_w_data = r_wdata;
    rdata       = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy    = 1'b1;
        lifo_wr = w_push_ok;
        lifo_rd = w_pop_ok;
        w_next  = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        ack0   = ~r_gnt;
        ack1   = r_gnt;
        err    = r_err;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Transaction datapath
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_gnt   <= 1'b0;
      r_op    <= 1'b0;
      r_wdata <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_occ   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_op    <= w_win ? op1 : op0;
            r_wdata <= w_win ? wdata1 : wdata0;
            r_full  <= w_full;
            r_empty <= w_empty;
          end
        end
        S_ISSUE: begin
          r_err <= r_op ? r_full : r_empty;
          if (w_pop_ok) begin
            // Lifo data is combinational: this is the pre-pop top of stack.
            r_rdata <= lifo_r_data;
            r_occ   <= r_occ - 1'b1;
          end else if (w_push_ok) begin
            r_occ   <= r_occ + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
